// File: rtl/flash_rdcache.sv
// Direct-mapped read-only word cache between the CPU flash window and spimemio.
// Latency: hit -> cpu_ready 1 cycle after request; miss -> 1 cycle after mem_ready.
// Backpressure: cpu_valid is held until cpu_ready; mem_valid is held until mem_ready.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   cpu_valid/ready/addr/rdata   CPU read request; cpu_ready is a 1-cycle pulse
//   mem_valid/ready/addr/rdata   one-word read to spimemio on a miss
//   flush                    invalidate every line (tied to spimemio cfgreg writes)
//   stat_hits, stat_misses   present only when FLASH_RDCACHE_STATS_EN is defined
module flash_rdcache #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_rdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              flush
`ifdef FLASH_RDCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - IW - 2;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t           state;
    logic [LINES-1:0] line_vld;
    logic [TW-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES];
    // Remembers a flush seen earlier in the current fill so the line
    // being fetched (possibly under the old flash mode) is not kept.
    logic             flush_seen;

    logic [IW-1:0]    lk_idx;
    logic [TW-1:0]    lk_tag;
    logic             lk_hit;
    logic [IW-1:0]    fill_idx;
    logic [TW-1:0]    fill_tag;
    logic             fill_done;
    logic             hit_go;
    logic             miss_go;
    logic             unused_addr_lsb;

    assign lk_idx   = cpu_addr[IW+1:2];
    assign lk_tag   = cpu_addr[ADDR_W-1:IW+2];
    assign lk_hit   = line_vld[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // The fill line is addressed from the registered mem_addr, not the live cpu_addr.
    assign fill_idx  = mem_addr[IW+1:2];
    assign fill_tag  = mem_addr[ADDR_W-1:IW+2];
    assign fill_done = (state == FILL) && mem_ready;

    // A flush coinciding with a lookup forces a miss.
    assign hit_go   = (state == IDLE) && cpu_valid && lk_hit && !flush;
    assign miss_go  = (state == IDLE) && cpu_valid && (!lk_hit || flush);

    assign unused_addr_lsb = ^cpu_addr[1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= 32'h0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            line_vld   <= '0;
            flush_seen <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit_go) begin
                        cpu_rdata <= data_q[lk_idx];
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end else if (miss_go) begin
                        mem_valid  <= 1'b1;
                        mem_addr   <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        flush_seen <= 1'b0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        cpu_rdata <= mem_rdata;
                        cpu_ready <= 1'b1;
                        if (!flush_seen) begin
                            line_vld[fill_idx] <= 1'b1;
                        end
                        state <= RESP;
                    end else if (flush) begin
                        flush_seen <= 1'b1;
                    end
                end
                RESP: begin
                    // The CPU drops cpu_valid here; any request level is ignored.
                    cpu_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Last assignment wins, so a flush beats a fill on the same edge.
            if (flush) begin
                line_vld <= '0;
            end
        end
    end

    // Tag/data need no reset: they are only read when the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata;
        end
    end

`ifdef FLASH_RDCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_hits   <= 32'h0;
            stat_misses <= 32'h0;
        end else begin
            if (hit_go) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (miss_go) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule
